// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared types and default timing for the LED-matrix scan controller.
// Optional feature macro used by the top level: MATRIX_TEST_PATTERN_EN.
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2,
        ST_SYNC  = 2'd3
    } scan_state_e;

    localparam int DEF_ADDR_DEPTH   = 4;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_DWELL_CYCLES = 16;
    localparam int DEF_BLANK_CYCLES = 2;

    localparam int ROWS = 2 ** DEF_ADDR_DEPTH;

    // Clocks from one frame start to the next: every row dwells and blanks, plus the sync cycle.
    function automatic int frame_cycles(input int addr_depth, input int dwell, input int blank_c);
        return (2 ** addr_depth) * (dwell + blank_c) + 1;
    endfunction

    localparam int FRAME_CYCLES = frame_cycles(DEF_ADDR_DEPTH, DEF_DWELL_CYCLES, DEF_BLANK_CYCLES);

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Row-buffer RAM port: write side fed from the host, read side feeding the scan.
interface matrix_scan_ctrl_if
    import matrix_pkg::*;
#(
    parameter int ADDR_DEPTH = DEF_ADDR_DEPTH,
    parameter int DATA_W     = DEF_DATA_W
);
    logic                  mem_we;
    logic [ADDR_DEPTH:0]   mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [ADDR_DEPTH:0]   mem_raddr;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (output mem_we, mem_waddr, mem_wdata, mem_raddr, input mem_rdata);
    modport slave  (input mem_we, mem_waddr, mem_wdata, mem_raddr, output mem_rdata);
endinterface

// File: rtl/matrix_scan_ctrl_host_sync.sv
// Brings one asynchronous host control line into the clk_100mhz domain and
// flags its rising edge for exactly one clock.
module matrix_host_sync (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;
endmodule

// File: rtl/matrix_scan_ctrl.sv
// LED-matrix scan scheduler and host-write controller over a double-banked row buffer.
// Optional macro MATRIX_TEST_PATTERN_EN: test_mode=1 replaces buffer data with a walking one.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int ADDR_DEPTH   = DEF_ADDR_DEPTH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    RPI_IO,
    input  logic                 write_strobe,
    input  logic                 host_commit,
    input  logic                 enable,
    input  logic                 test_mode,
    matrix_scan_ctrl_if.master   mem,
    output logic [DATA_W-1:0]    row_data,
    output logic                 row_valid,
    output logic                 blank,
    output logic                 sync,
    output logic                 overrun,
    output logic [15:0]          frame_count
);
    localparam int N_ROWS = 2 ** ADDR_DEPTH;
    localparam int DW_W   = $clog2(DWELL_CYCLES + 1);
    localparam int BL_W   = $clog2(BLANK_CYCLES + 1);
    localparam logic [DW_W-1:0]       DWELL_LAST  = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DW_W-1:0]       DWELL_LOAD  = DW_W'(1);
    localparam logic [DW_W-1:0]       DWELL_VALID = DW_W'(2);
    localparam logic [BL_W-1:0]       BLANK_LAST  = BL_W'(BLANK_CYCLES - 1);
    localparam logic [ADDR_DEPTH-1:0] ROW_LAST    = {ADDR_DEPTH{1'b1}};
    localparam logic [ADDR_DEPTH:0]   WR_FULL     = (ADDR_DEPTH + 1)'(N_ROWS);

    scan_state_e            state_r, state_n;
    logic [DW_W-1:0]        dwell_r, dwell_n;
    logic [BL_W-1:0]        blank_cnt_r, blank_cnt_n;
    logic [ADDR_DEPTH-1:0]  rd_addr_r, rd_addr_n;
    logic                   enter_sync_s;

    logic                   wr_rise_s, commit_rise_s, consume_s, wr_full_s;
    logic [DATA_W-1:0]      data_p1_r, data_p2_r;
    logic                   mem_we_r;
    logic [ADDR_DEPTH:0]    mem_waddr_r, wr_addr_r;
    logic [DATA_W-1:0]      mem_wdata_r, row_data_r, row_src_s;
    logic                   front_bank_r, swap_pending_r;
    logic                   row_valid_r, blank_r, sync_r, overrun_r;
    logic [15:0]            frame_count_r;

    matrix_host_sync u_wr_sync (
        .clk_100mhz (clk_100mhz), .rst_n (rst_n), .async_in (write_strobe), .rise (wr_rise_s)
    );
    matrix_host_sync u_commit_sync (
        .clk_100mhz (clk_100mhz), .rst_n (rst_n), .async_in (host_commit), .rise (commit_rise_s)
    );

`ifdef MATRIX_TEST_PATTERN_EN
    logic [DATA_W-1:0] pattern_s;
    // Walking-one test image keyed on the scanned row, chosen instead of buffer data in test mode.
    always_comb begin
        pattern_s = {{(DATA_W-1){1'b0}}, 1'b1} << (32'(rd_addr_r) % DATA_W);
        if (test_mode) begin
            row_src_s = pattern_s;
        end else begin
            row_src_s = mem.mem_rdata;
        end
    end
`else
    logic unused_test_mode_s;
    assign unused_test_mode_s = test_mode;
    assign row_src_s          = mem.mem_rdata;
`endif

    // Scan sequencing: row dwell, blanking gap, frame sync, and idle when disabled.
    always_comb begin
        state_n      = state_r;
        dwell_n      = dwell_r;
        blank_cnt_n  = blank_cnt_r;
        rd_addr_n    = rd_addr_r;
        enter_sync_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_n   = ST_SCAN;
                    dwell_n   = '0;
                    rd_addr_n = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (dwell_r == DWELL_LAST) begin
                    state_n     = ST_BLANK;
                    blank_cnt_n = '0;
                end else begin
                    dwell_n = dwell_r + 1'b1;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_r != BLANK_LAST) begin
                    blank_cnt_n = blank_cnt_r + 1'b1;
                end else if (rd_addr_r == ROW_LAST) begin
                    state_n      = ST_SYNC;
                    rd_addr_n    = '0;
                    enter_sync_s = 1'b1;
                end else begin
                    state_n   = ST_SCAN;
                    dwell_n   = '0;
                    rd_addr_n = rd_addr_r + 1'b1;
                end
            end
            ST_SYNC: begin
                dwell_n   = '0;
                rd_addr_n = '0;
                if (enable) begin
                    state_n = ST_SCAN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and the driver-facing strobes, registered in step with the state.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            dwell_r       <= '0;
            blank_cnt_r   <= '0;
            rd_addr_r     <= '0;
            blank_r       <= 1'b1;
            row_valid_r   <= 1'b0;
            sync_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r       <= state_n;
            dwell_r       <= dwell_n;
            blank_cnt_r   <= blank_cnt_n;
            rd_addr_r     <= rd_addr_n;
            blank_r       <= (state_n != ST_SCAN);
            row_valid_r   <= (state_n == ST_SCAN) && (dwell_n >= DWELL_VALID);
            sync_r        <= enter_sync_s;
            frame_count_r <= enter_sync_s ? frame_count_r + 16'd1 : frame_count_r;
        end
    end

    // Capture row pixels one clock after the read address settles (RAM has one cycle latency).
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            row_data_r <= '0;
        end else if ((state_r == ST_SCAN) && (dwell_r == DWELL_LOAD)) begin
            row_data_r <= row_src_s;
        end else begin
            row_data_r <= row_data_r;
        end
    end

    assign wr_full_s = (wr_addr_r == WR_FULL);
    assign consume_s = enter_sync_s & swap_pending_r;

    // Host writes into the back bank, commit bookkeeping, bank swap at frame sync, error pulses.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            data_p1_r      <= '0;
            data_p2_r      <= '0;
            mem_we_r       <= 1'b0;
            mem_waddr_r    <= '0;
            mem_wdata_r    <= '0;
            wr_addr_r      <= '0;
            front_bank_r   <= 1'b0;
            swap_pending_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            // Data follows the same two-stage delay as the strobe synchroniser.
            data_p1_r <= RPI_IO;
            data_p2_r <= data_p1_r;
            mem_we_r  <= wr_rise_s & ~wr_full_s;
            if (wr_rise_s && !wr_full_s) begin
                mem_waddr_r <= {~front_bank_r, wr_addr_r[ADDR_DEPTH-1:0]};
                mem_wdata_r <= data_p2_r;
            end else begin
                mem_waddr_r <= mem_waddr_r;
                mem_wdata_r <= mem_wdata_r;
            end
            // A swap in the same cycle as a write wins the address reset; the write itself used the old bank.
            if (consume_s) begin
                wr_addr_r <= '0;
            end else if (wr_rise_s && !wr_full_s) begin
                wr_addr_r <= wr_addr_r + 1'b1;
            end else begin
                wr_addr_r <= wr_addr_r;
            end
            front_bank_r <= consume_s ? ~front_bank_r : front_bank_r;
            if (commit_rise_s) begin
                swap_pending_r <= 1'b1;
            end else if (consume_s) begin
                swap_pending_r <= 1'b0;
            end else begin
                swap_pending_r <= swap_pending_r;
            end
            overrun_r <= (wr_rise_s & wr_full_s) | (commit_rise_s & swap_pending_r & ~consume_s);
        end
    end

    assign mem.mem_we    = mem_we_r;
    assign mem.mem_waddr = mem_waddr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign mem.mem_raddr = {front_bank_r, rd_addr_r};
    assign row_data      = row_data_r;
    assign row_valid     = row_valid_r;
    assign blank         = blank_r;
    assign sync          = sync_r;
    assign overrun       = overrun_r;
    assign frame_count   = frame_count_r;
endmodule
